// File: rtl/multi_channel_apb_timer.sv
// Purpose : NUM_CH independent periodic/one-shot timers on APB3, combined FABINT plus per-channel TICK.
// Latency : APB zero wait states; PRDATA combinational from PADDR; TICK/FABINT registered, one cycle.
// Backpressure: none; PREADY is tied high, so every access completes in its access phase.
//
// Ports: PCLK/PRESET (sync, active-high); APB3 slave PSEL/PENABLE/PWRITE/PADDR[7:0]/PWDATA/PRDATA/
//        PREADY/PSLVERR; FABINT = registered OR of enabled STATUS bits; TICK[NUM_CH] = expiry pulses.
// Register map: channel n at n*0x10 {PERIOD, CTRL{IRQ_EN,ONESHOT,EN}, COUNT, STATUS(W1C)}; 0x80 IRQSUM.
// Optional macro TIMER_PRESCALE_EN adds 0x84 PRESCALE (16 bits) and a shared advance strobe.
module multi_channel_apb_timer #(
    parameter int          NUM_CH         = 4,
    parameter int          CNT_W          = 32,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd2500000,
    parameter logic [7:0]  RST_EN_MASK    = 8'd1
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [7:0]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              FABINT,
    output logic [NUM_CH-1:0] TICK
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [CNT_W-1:0]  count_q  [NUM_CH];
    logic [NUM_CH-1:0] en_q, oneshot_q, irq_en_q, status_q;
    logic [NUM_CH-1:0] irq_vec, expire, ch_sel;
    logic              acc, wr_en, irqsum_hit, pre_hit, mapped, advance;
    logic [31:0]       rd_data;
    logic              unused_bits;

    assign unused_bits = ^{PADDR[1:0], PWDATA};

    assign acc     = PSEL & PENABLE;
    assign wr_en   = acc & PWRITE;
    assign irq_vec = status_q & irq_en_q;

    // One-hot channel decode; blocks at or above NUM_CH never match and fall out as unmapped.
    always_comb begin
        ch_sel = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            ch_sel[n] = !PADDR[7] && (PADDR[6:4] == 3'(n));
        end
    end

    assign irqsum_hit = (PADDR[7:2] == 6'b100000);

`ifdef TIMER_PRESCALE_EN
    logic [15:0] prescale_q, pre_cnt_q;

    assign pre_hit = (PADDR[7:2] == 6'b100001);
    // Strobe on the last count of the prescale window; PRESCALE=0 advances every cycle.
    assign advance = (pre_cnt_q == prescale_q);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            prescale_q <= '0;
            pre_cnt_q  <= '0;
        end else if (wr_en && pre_hit) begin
            prescale_q <= PWDATA[15:0];
            pre_cnt_q  <= '0;
        end else begin
            pre_cnt_q  <= advance ? 16'd0 : pre_cnt_q + 16'd1;
        end
    end
`else
    assign pre_hit = 1'b0;
    assign advance = 1'b1;
`endif

    assign mapped = (|ch_sel) | irqsum_hit | pre_hit;

    // Compare is >=, so a PERIOD shrunk below COUNT expires at the next advance instead of wrapping.
    always_comb begin
        expire = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            expire[n] = en_q[n] && advance && (count_q[n] >= period_q[n]);
        end
    end

    always_comb begin
        rd_data = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (ch_sel[n]) begin
                case (PADDR[3:2])
                    2'd0:    rd_data = 32'(period_q[n]);
                    2'd1:    rd_data = {29'd0, irq_en_q[n], oneshot_q[n], en_q[n]};
                    2'd2:    rd_data = 32'(count_q[n]);
                    default: rd_data = {31'd0, status_q[n]};
                endcase
            end
        end
        if (irqsum_hit) rd_data = 32'(irq_vec);
`ifdef TIMER_PRESCALE_EN
        if (pre_hit) rd_data = {16'd0, prescale_q};
`endif
    end

    // Read data is only driven while a read is selected so the bus idles at zero.
    assign PRDATA  = (PSEL && !PWRITE) ? rd_data : 32'd0;
    assign PREADY  = 1'b1;
    assign PSLVERR = acc & ~mapped;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int n = 0; n < NUM_CH; n++) begin
                period_q[n] <= DEFAULT_PERIOD[CNT_W-1:0];
                count_q[n]  <= '0;
            end
            en_q      <= RST_EN_MASK[NUM_CH-1:0];
            oneshot_q <= '0;
            irq_en_q  <= RST_EN_MASK[NUM_CH-1:0];
            status_q  <= '0;
            TICK      <= '0;
            FABINT    <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                TICK[n] <= expire[n];

                if (!en_q[n] || expire[n]) begin
                    count_q[n] <= '0;
                end else if (advance) begin
                    count_q[n] <= count_q[n] + CNT_ONE;
                end

                if (expire[n] && oneshot_q[n]) en_q[n] <= 1'b0;

                // Register writes come after the counting updates so a CTRL write beats a one-shot clear.
                if (wr_en && ch_sel[n]) begin
                    case (PADDR[3:2])
                        2'd0: period_q[n] <= PWDATA[CNT_W-1:0];
                        2'd1: begin
                            en_q[n]      <= PWDATA[0];
                            oneshot_q[n] <= PWDATA[1];
                            irq_en_q[n]  <= PWDATA[2];
                            if (!en_q[n] && PWDATA[0]) count_q[n] <= '0;
                        end
                        2'd3: if (PWDATA[0]) status_q[n] <= 1'b0;
                        default: ;
                    endcase
                end

                // Expiry set is applied last so it wins over a coincident W1C.
                if (expire[n]) status_q[n] <= 1'b1;
            end
            FABINT <= |irq_vec;
        end
    end

endmodule

// File: tb/tb_multi_channel_apb_timer.sv
module tb_multi_channel_apb_timer;

    logic        PCLK = 1'b0;
    logic        PRESET, PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR, FABINT;
    logic [3:0]  TICK;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  tick_hist;
    logic [31:0] rd;
    logic        err;
    int          n;

    multi_channel_apb_timer #(
        .NUM_CH(4), .CNT_W(32), .DEFAULT_PERIOD(32'd9), .RST_EN_MASK(8'd1)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .FABINT(FABINT), .TICK(TICK)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge PCLK);
        #1;
        tick_hist = tick_hist | TICK;
    endtask

    // Two-cycle APB write; the write commits on the second edge, returns 1 ns after it.
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    // Combinational read between edges; consumes no clock.
    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = a;
        #1;
        d = PRDATA; e = PSLVERR;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Cycles until TICK[ch] is seen, bounded at 60.
    task automatic wait_tick(input int ch, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!TICK[ch] && cyc < 60);
    endtask

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        tick_hist = '0;
        repeat (3) tick();

        // Reset state
        check("rst_tick", 32'(TICK), 32'h0);
        check("rst_fabint", 32'(FABINT), 32'h0);
        check("rst_prdata_idle", PRDATA, 32'h0);
        check("rst_pslverr_idle", 32'(PSLVERR), 32'h0);
        check("rst_pready", 32'(PREADY), 32'h1);
        apb_read(8'h00, rd, err); check("rst_period0", rd, 32'd9);
        apb_read(8'h04, rd, err); check("rst_ctrl0", rd, 32'h5);
        apb_read(8'h14, rd, err); check("rst_ctrl1", rd, 32'h0);
        apb_read(8'h08, rd, err); check("rst_count0", rd, 32'h0);

        // Channel 0 default tick: period 10 cycles, FABINT one cycle after STATUS
        PRESET = 1'b0;
        tick_hist = '0;
        wait_tick(0, n);
        check("ch0_first_tick_cycles", 32'(n), 32'd10);
        check("ch0_fabint_not_yet", 32'(FABINT), 32'h0);
        apb_read(8'h0C, rd, err); check("ch0_status_set", rd, 32'h1);
        tick();
        check("ch0_fabint_rise", 32'(FABINT), 32'h1);
        check("ch0_tick_one_cycle", 32'(TICK[0]), 32'h0);
        wait_tick(0, n);
        check("ch0_tick_interval", 32'(n), 32'd9);
        check("others_silent", 32'(tick_hist[3:1]), 32'h0);

        // W1C away from expiry, then coincident with expiry (edge E20 is now)
        apb_write(8'h0C, 32'h1);
        apb_read(8'h0C, rd, err); check("w1c_clear", rd, 32'h0);
        check("w1c_fabint_lag", 32'(FABINT), 32'h1);
        tick();
        check("w1c_fabint_fall", 32'(FABINT), 32'h0);
        repeat (5) tick();
        apb_write(8'h0C, 32'h1);
        check("w1c_coincident_tick", 32'(TICK[0]), 32'h1);
        apb_read(8'h0C, rd, err); check("w1c_coincident_set_wins", rd, 32'h1);
        apb_write(8'h0C, 32'h1);
        apb_read(8'h0C, rd, err); check("w1c_late_clear", rd, 32'h0);
        check("w1c_late_fabint_hold", 32'(FABINT), 32'h1);
        tick();
        check("w1c_late_fabint_fall", 32'(FABINT), 32'h0);

        // IRQ_EN cleared with EN 1->1: count keeps running, STATUS set but FABINT masked
        apb_write(8'h04, 32'h1);
        wait_tick(0, n);
        check("en_1to1_count_kept", 32'(n), 32'd5);
        tick();
        check("irq_mask_fabint", 32'(FABINT), 32'h0);
        apb_read(8'h0C, rd, err); check("irq_mask_status", rd, 32'h1);
        apb_read(8'h80, rd, err); check("irq_mask_irqsum", rd, 32'h0);
        apb_write(8'h04, 32'h0);
        apb_write(8'h0C, 32'h1);

        // Channel 1 periodic, PERIOD=4
        apb_write(8'h10, 32'd4);
        apb_write(8'h14, 32'h5);
        apb_read(8'h18, rd, err); check("ch1_count_0", rd, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            apb_read(8'h18, rd, err); check("ch1_count_ramp", rd, 32'(k));
        end
        tick();
        check("ch1_tick", 32'(TICK[1]), 32'h1);
        apb_read(8'h18, rd, err); check("ch1_count_wrap", rd, 32'd0);
        apb_read(8'h80, rd, err); check("ch1_irqsum", rd, 32'h2);
        wait_tick(1, n);
        check("ch1_tick_interval", 32'(n), 32'd5);
        tick();
        check("ch1_fabint", 32'(FABINT), 32'h1);
        apb_write(8'h14, 32'h0);
        apb_write(8'h1C, 32'h1);
        tick();
        check("ch1_fabint_cleared", 32'(FABINT), 32'h0);

        // Channel 2 one-shot without IRQ
        apb_write(8'h20, 32'd3);
        apb_write(8'h24, 32'h3);
        wait_tick(2, n);
        check("ch2_oneshot_delay", 32'(n), 32'd4);
        apb_read(8'h24, rd, err); check("ch2_ctrl_en_cleared", rd, 32'h2);
        apb_read(8'h2C, rd, err); check("ch2_status", rd, 32'h1);
        check("ch2_fabint_quiet", 32'(FABINT), 32'h0);
        tick_hist = '0;
        repeat (20) tick();
        check("ch2_single_tick", 32'(tick_hist[2]), 32'h0);
        check("ch2_fabint_still_quiet", 32'(FABINT), 32'h0);

        // Channel 1 PERIOD shrink below COUNT
        apb_write(8'h10, 32'd20);
        apb_write(8'h14, 32'h5);
        repeat (6) tick();
        apb_read(8'h18, rd, err); check("ch1_count_6", rd, 32'd6);
        apb_write(8'h10, 32'd2);
        check("shrink_no_tick_yet", 32'(TICK[1]), 32'h0);
        apb_read(8'h18, rd, err); check("shrink_count_8", rd, 32'd8);
        tick();
        check("shrink_expire_next", 32'(TICK[1]), 32'h1);
        apb_read(8'h18, rd, err); check("shrink_count_zero", rd, 32'd0);

        // Unmapped addresses and access-phase qualification
        apb_read(8'h40, rd, err);
        check("unmapped_40_data", rd, 32'h0);
        check("unmapped_40_slverr", 32'(err), 32'h1);
        apb_read(8'h00, rd, err); check("mapped_slverr", 32'(err), 32'h0);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h40;
        #1;
        check("setup_phase_slverr", 32'(PSLVERR), 32'h0);
        PSEL = 1'b0;
`ifdef TIMER_PRESCALE_EN
        apb_write(8'h84, 32'd3);
        apb_write(8'h00, 32'd1);
        apb_write(8'h04, 32'h1);
        apb_read(8'h84, rd, err);
        check("prescale_read", rd, 32'd3);
        check("prescale_slverr", 32'(err), 32'h0);
        wait_tick(0, n);
        wait_tick(0, n);
        check("prescale_interval", 32'(n), 32'd8);
`else
        apb_read(8'h84, rd, err);
        check("no_prescale_data", rd, 32'h0);
        check("no_prescale_slverr", 32'(err), 32'h1);
`endif

        // Reset mid-count restores reset values on the same edge
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        check("rst2_tick", 32'(TICK), 32'h0);
        check("rst2_fabint", 32'(FABINT), 32'h0);
        apb_read(8'h18, rd, err); check("rst2_count1", rd, 32'h0);
        apb_read(8'h14, rd, err); check("rst2_ctrl1", rd, 32'h0);
        apb_read(8'h10, rd, err); check("rst2_period1", rd, 32'd9);
        apb_read(8'h2C, rd, err); check("rst2_status2", rd, 32'h0);
        apb_read(8'h04, rd, err); check("rst2_ctrl0", rd, 32'h5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_channel_apb_timer.md
Name: multi_channel_apb_timer

Overview:
- Parametrised successor to the single fixed-period fabric interrupt timer.
- Provides NUM_CH independent down-the-fabric periodic/one-shot timers, each with a software-programmable period, mode, interrupt enable and sticky W1C status.
- Sits on the APB3 fabric bus and drives a single combined FABINT line to the processor plus per-channel tick pulses for fabric logic.
- After reset, channel 0 runs at DEFAULT_PERIOD with interrupt enabled, matching legacy 1 ms tick behaviour with no software setup.

Parameters:
- NUM_CH, 4, number of timer channels (1..8).
- CNT_W, 32, counter/period width in bits (8..32).
- DEFAULT_PERIOD, 2500000, reset value of every PERIOD register.
- RST_EN_MASK, 1, per-channel bitmask of channels that come out of reset with EN=1, ONESHOT=0 and IRQ_EN=1.

Ports:
- PCLK  in  1  fabric/APB clock; all logic on rising edge.
- PRESET  in  1  synchronous active-high reset.
- PSEL  in  1  APB3 select.
- PENABLE  in  1  APB3 access phase.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  8  byte address; bits [1:0] ignored.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data, combinational from PADDR.
- PREADY  out  1  tied 1; zero wait states.
- PSLVERR  out  1  1 during access phase to an unmapped address.
- FABINT  out  1  registered OR of (STATUS & IRQ_EN) across channels.
- TICK  out  NUM_CH  one-cycle registered pulse per channel expiry.

Behaviour:
- Interface: one clock (PCLK); reset (PRESET) is synchronous and active-high.
- Register map, channel n block at n*0x10:
  - +0x0 PERIOD, RW, CNT_W bits, zero-extended on read.
  - +0x4 CTRL, RW: bit0 EN, bit1 ONESHOT, bit2 IRQ_EN.
  - +0x8 COUNT, RO.
  - +0xC STATUS, bit0 EXPIRED, write-1-to-clear.
- Global 0x80 IRQSUM, RO: bit n = STATUS_n & IRQ_EN_n.
- Any other address, including channel blocks at or above NUM_CH: reads 0, writes ignored, PSLVERR=1.
- Writes commit on the PCLK edge where PSEL&PENABLE&PWRITE. PSLVERR=0 outside the access phase.
- Reset values:
  - PERIOD=DEFAULT_PERIOD, COUNT=0, STATUS=0.
  - CTRL per RST_EN_MASK.
  - FABINT=0, TICK=0, PRDATA=0 when idle.
- Counting (per channel, per cycle):
  - EN=0: COUNT<=0.
  - EN=1 and COUNT>=PERIOD: expiry. COUNT<=0, STATUS<=1, TICK_n<=1, and if ONESHOT then EN<=0.
  - Otherwise: COUNT<=COUNT+1, TICK_n<=0.
  - Period is therefore PERIOD+1 cycles. PERIOD=0 expires every cycle.
- Compare is >=, so shrinking PERIOD below the current COUNT expires on the next cycle; no 2^CNT_W wrap.
- Writing CTRL with EN 0->1: COUNT<=0. Writing CTRL with EN 1->1 leaves COUNT untouched.
- Writing PERIOD while running takes effect on the next compare; COUNT is not reset.
- Simultaneous W1C of STATUS and expiry in the same cycle: set wins, STATUS stays 1.
- CTRL write setting EN=1 in the same cycle a one-shot expiry clears EN: the register write wins, EN=1.
- FABINT is registered: it asserts one cycle after STATUS rises, provided IRQ_EN=1. It stays high until all enabled STATUS bits are cleared.
- Clearing IRQ_EN masks FABINT but leaves STATUS set.
- PRESET mid-count aborts all channels and restores reset values on the same edge.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - Adds global register 0x84 PRESCALE, RW, 16 bits, reset 0.
  - A shared prescale counter runs 0..PRESCALE and emits an internal advance strobe on wrap.
  - Channel COUNT increments and expiry checks occur only on strobe cycles, so the period is (PERIOD+1)*(PRESCALE+1) cycles.
  - Writing PRESCALE resets the prescale counter to 0.
- Undefined:
  - Counters advance every cycle.
  - 0x84 is unmapped: reads 0, PSLVERR=1.

Test Plan:
- Reset, no APB traffic, DEFAULT_PERIOD overridden to 9 for sim -> TICK[0] pulses every 10 cycles; FABINT rises 1 cycle after STATUS0; other channels stay silent.
- Ch1: write PERIOD=4, CTRL=0x5 -> TICK[1] every 5 cycles; COUNT reads 0..4 cyclically; IRQSUM bit1=1 after first expiry.
- Ch2: PERIOD=3, CTRL=0x3 (one-shot, no IRQ) -> exactly one TICK[2] after 4 cycles; CTRL reads 0x2; STATUS2=1; FABINT unaffected.
- W1C STATUS0 in the exact expiry cycle -> STATUS0 remains 1. W1C one cycle later -> STATUS0=0 and FABINT falls next cycle.
- Ch1 running with COUNT=7: write PERIOD=2 -> expiry on the following cycle. Read 0x40 with NUM_CH=4 -> PRDATA=0, PSLVERR=1.
- With TIMER_PRESCALE_EN: PRESCALE=3, ch0 PERIOD=1 -> TICK[0] every 8 cycles. Without the macro: read 0x84 -> PSLVERR=1.
